// File: rtl/fibo_scheduler.sv
// Round-robin scheduler that shares one Fibonacci counter among N_REQ requesters.
// It grants one job at a time, drives the counter, and returns the result with a done pulse.
module fibo_scheduler #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int R_size = 16,
  parameter int C_size = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*R_size-1:0]  req_data1,
  input  logic [N_REQ*R_size-1:0]  req_data2,
  input  logic [N_REQ*C_size-1:0]  req_data3,
  output logic [N_REQ-1:0]         done,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [R_size-1:0]        rsp_result,
  output logic                     busy,
  output logic                     fc_start,
  output logic [R_size-1:0]        fc_data1,
  output logic [R_size-1:0]        fc_data2,
  output logic [C_size-1:0]        fc_data3,
  input  logic                     fc_ready,
  input  logic [R_size-1:0]        fc_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                abort_q, abort_d;
  logic                fc_start_q, fc_start_d;
  logic [R_size-1:0]   fc_data1_q, fc_data1_d;
  logic [R_size-1:0]   fc_data2_q, fc_data2_d;
  logic [C_size-1:0]   fc_data3_q, fc_data3_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [R_size-1:0]   rsp_result_q, rsp_result_d;
  logic                busy_q, busy_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic                job_dropped;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && req[ID_W'((int'(ptr_q) + k) % N_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= ID_W'(N_REQ - 1);
      gid_q        <= '0;
      abort_q      <= 1'b0;
      fc_start_q   <= 1'b0;
      fc_data1_q   <= '0;
      fc_data2_q   <= '0;
      fc_data3_q   <= '0;
      done_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gid_q        <= gid_d;
      abort_q      <= abort_d;
      fc_start_q   <= fc_start_d;
      fc_data1_q   <= fc_data1_d;
      fc_data2_q   <= fc_data2_d;
      fc_data3_q   <= fc_data3_d;
      done_q       <= done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
    end
  end

  // The counter drops Ready on the start edge, so WAIT never sees a stale Ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found && fc_ready) state_d = S_ISSUE;
      S_ISSUE: if (fc_ready) state_d = S_WAIT;
      S_WAIT:  if (fc_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    ptr_d        = ptr_q;
    gid_d        = gid_q;
    abort_d      = abort_q;
    fc_data1_d   = fc_data1_q;
    fc_data2_d   = fc_data2_q;
    fc_data3_d   = fc_data3_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    done_d       = '0;
    rsp_valid_d  = 1'b0;
    fc_start_d   = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    job_dropped  = abort_q | ~req[gid_q];

    case (state_q)
      S_IDLE: begin
        if (state_d == S_ISSUE) begin
          ptr_d      = grant_id;
          gid_d      = grant_id;
          abort_d    = 1'b0;
          fc_data1_d = req_data1[grant_id*R_size +: R_size];
          fc_data2_d = req_data2[grant_id*R_size +: R_size];
          fc_data3_d = req_data3[grant_id*C_size +: C_size];
        end
      end
      S_WAIT: begin
        // A requester that lets go of req mid-job forfeits its completion pulse.
        abort_d = job_dropped;
        if (fc_ready) begin
          rsp_result_d = fc_result;
          if (!job_dropped) begin
            done_d[gid_q] = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_id_d      = gid_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign fc_start   = fc_start_q;
  assign fc_data1   = fc_data1_q;
  assign fc_data2   = fc_data2_q;
  assign fc_data3   = fc_data3_q;
  assign done       = done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fibo_scheduler.sv
// Bench for fibo_scheduler: behavioural Fibonacci counter plus a response scoreboard.
// Expected responses are queued when requests are driven and popped on each rsp_valid.
module tb_fibo_scheduler;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int RW   = 16;
  localparam int CW   = 8;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*RW-1:0]   req_data1;
  logic [N*RW-1:0]   req_data2;
  logic [N*CW-1:0]   req_data3;
  logic [N-1:0]      done;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [RW-1:0]     rsp_result;
  logic              busy;
  logic              fc_start;
  logic [RW-1:0]     fc_data1;
  logic [RW-1:0]     fc_data2;
  logic [CW-1:0]     fc_data3;
  logic              fc_ready;
  logic [RW-1:0]     fc_result;

  logic [RW-1:0]     d1 [N];
  logic [RW-1:0]     d2 [N];
  logic [CW-1:0]     d3 [N];

  typedef struct {
    int id;
    int res;
  } exp_t;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   fc_cnt     = 0;

  fibo_scheduler #(.N_REQ(N), .ID_W(IDW), .R_size(RW), .C_size(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_data3  (req_data3),
    .done       (done),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .fc_start   (fc_start),
    .fc_data1   (fc_data1),
    .fc_data2   (fc_data2),
    .fc_data3   (fc_data3),
    .fc_ready   (fc_ready),
    .fc_result  (fc_result)
  );

  always #5 clock = ~clock;

  always_comb begin
    req_data1 = '0;
    req_data2 = '0;
    req_data3 = '0;
    for (int i = 0; i < N; i++) begin
      req_data1[i*RW +: RW] = d1[i];
      req_data2[i*RW +: RW] = d2[i];
      req_data3[i*CW +: CW] = d3[i];
    end
  end

  function automatic logic [RW-1:0] fib(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                        input logic [CW-1:0] n);
    logic [RW-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < int'(n); i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return y;
  endfunction

  // Counter model: Ready drops on the start edge and returns 2n+1 edges later.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fc_ready  <= 1'b1;
      fc_result <= '0;
      fc_cnt    <= 0;
    end else if (fc_start && fc_ready) begin
      fc_ready  <= 1'b0;
      fc_result <= fib(fc_data1, fc_data2, fc_data3);
      fc_cnt    <= 2 * int'(fc_data3) + 1;
    end else if (!fc_ready) begin
      if (fc_cnt == 1) fc_ready <= 1'b1;
      fc_cnt <= fc_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && (rsp_valid === 1'b1 || done !== '0)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, e.id);
        check("rsp_result", rsp_result, e.res);
        check("done_onehot", done, 1 << e.id);
      end
    end
  end

  task automatic push_exp(input int id, input int res);
    exp_t e;
    e.id  = id;
    e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic set_job(input int id, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic [CW-1:0] n);
    d1[id] = a;
    d2[id] = b;
    d3[id] = n;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Lone request from an idle scheduler: checks issue, latency and pulse width.
  task automatic run_single(input int id, input logic [RW-1:0] a, input logic [RW-1:0] b,
                            input logic [CW-1:0] n, input logic [RW-1:0] exp_res);
    int cyc;
    bit seen;
    set_job(id, a, b, n);
    push_exp(id, int'(exp_res));
    req[id] = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check("issue_start", fc_start, 1);
        check("issue_busy", busy, 1);
        check("issue_data1", fc_data1, a);
        check("issue_data2", fc_data2, b);
        check("issue_data3", fc_data3, n);
      end
      if (cyc == 2) check("start_one_cycle", fc_start, 0);
      if (rsp_valid) seen = 1'b1;
    end
    check("latency", cyc, 2 * int'(n) + 4);
    req[id] = 1'b0;
    @(negedge clock);
    check("done_width", done, 0);
    check("rsp_valid_width", rsp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_rsps(input int count, input bit drop);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < count && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (rsp_valid) begin
        got++;
        if (drop) req[rsp_id] = 1'b0;
      end
    end
    check("rsp_count", got, count);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) set_job(i, '0, '0, '0);

    repeat (2) @(negedge clock);
    check("rst_fc_start", fc_start, 0);
    check("rst_fc_data1", fc_data1, 0);
    check("rst_fc_data2", fc_data2, 0);
    check("rst_fc_data3", fc_data3, 0);
    check("rst_done", done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clock);

    run_single(0, 16'd4, 16'd5, 8'd6, 16'd97);
    run_single(2, 16'd7, 16'd11, 8'd0, 16'd11);
    run_single(3, 16'hFFFF, 16'h0001, 8'd1, 16'h0000);

    // Contention right after reset: requester 0 wins first, then round-robin order.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_job(i, 16'(i), 16'(i + 1), 8'd1);
      push_exp(i, 2 * i + 1);
    end
    req = '1;
    wait_rsps(N, 1'b1);
    @(negedge clock);

    // Two persistent requesters must alternate.
    set_job(0, 16'd1, 16'd1, 8'd3);
    set_job(1, 16'd2, 16'd3, 8'd2);
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 5);
      push_exp(1, 8);
    end
    req[0] = 1'b1;
    req[1] = 1'b1;
    wait_rsps(6, 1'b0);
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clock);

    // Requester 1 abandons its job in WAIT; requester 3 is served next.
    set_job(1, 16'd0, 16'd1, 8'd10);
    req[1] = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_busy", busy, 1);
    req[1] = 1'b0;
    set_job(3, 16'd2, 16'd2, 8'd1);
    push_exp(3, 4);
    req[3] = 1'b1;
    wait_rsps(1, 1'b1);
    @(negedge clock);

    run_single(0, 16'd0, 16'd1, 8'd255, fib(16'd0, 16'd1, 8'd255));

    // Reset during WAIT clears every output at once.
    set_job(0, 16'd4, 16'd5, 8'd6);
    req[0] = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    req   = '0;
    #1;
    check("midrst_fc_start", fc_start, 0);
    check("midrst_fc_data1", fc_data1, 0);
    check("midrst_fc_data3", fc_data3, 0);
    check("midrst_done", done, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_result", rsp_result, 0);
    check("midrst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_single(0, 16'd3, 16'd4, 8'd2, 16'd11);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
